// File: rtl/divider_16bit_arbiter_if.sv
// Request/response bundle for the shared 16/8 divider.
// master: client side (drives requests, consumes responses); slave: divider.
interface divider_16bit_arbiter_if #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*8-1:0]  req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [15:0]        result;
    logic [15:0]        odd;
    logic               div_zero;
    logic               busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id,
        input  result, odd, div_zero, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id,
        output result, odd, div_zero, busy
    );
endinterface

// File: rtl/divider_16bit_arbiter.sv
// Round-robin shared iterative restoring divider, 16/8 unsigned, 1 bit/clk.
// Ports: clk, rst (async, active high), bus (slave modport: req/rsp handshakes).
module divider_16bit_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    divider_16bit_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   grant;
    logic            found;
    logic [15:0]     rem;
    logic [15:0]     quo;
    logic [7:0]      b_q;
    logic [3:0]      cnt;
    logic [ID_W-1:0] id_q;
    logic [15:0]     a_sel;
    logic [7:0]      b_sel;
    logic [15:0]     sh;
    logic [16:0]     diff;
    logic [15:0]     rem_nx;
    logic [15:0]     quo_nx;
    int              j;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ)
                j = j - NREQ;
            if (!found && bus.req_valid[j]) begin
                grant = PW'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && found)
            bus.req_ready[grant] = 1'b1;
    end

    assign a_sel = bus.req_a[16*grant +: 16];
    assign b_sel = bus.req_b[8*grant +: 8];
    assign bus.busy = (state != IDLE);

    // One restoring step; sign bit of the 17-bit difference decides.
    assign sh     = {rem[14:0], quo[15]};
    assign diff   = {1'b0, sh} - {9'b0, b_q};
    assign rem_nx = diff[16] ? sh : diff[15:0];
    assign quo_nx = {quo[14:0], ~diff[16]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            rem          <= '0;
            quo          <= '0;
            b_q          <= '0;
            cnt          <= '0;
            id_q         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id   <= '0;
            bus.result   <= '0;
            bus.odd      <= '0;
            bus.div_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        quo    <= a_sel;
                        b_q    <= b_sel;
                        rem    <= '0;
                        cnt    <= '0;
                        id_q   <= ID_W'(grant);
                        rr_ptr <= (grant == PW'(NREQ - 1)) ?
                                  '0 : grant + 1'b1;
                        state  <= (b_sel == 8'd0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        bus.result    <= quo_nx;
                        bus.odd       <= rem_nx;
                        bus.rsp_id    <= id_q;
                        bus.div_zero  <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    // Entered with rsp_valid low only on divide-by-zero:
                    // publish the saturated result one cycle after accept.
                    if (!bus.rsp_valid) begin
                        bus.result    <= 16'hFFFF;
                        bus.odd       <= quo;
                        bus.rsp_id    <= id_q;
                        bus.div_zero  <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
